// File: rtl/trivium_out_fifo.sv
// Trivium ciphertext output buffer: captures one 256-byte block, reports fill condition, byte-serial read port.
// Optional block XOR checksum outputs enabled by defining STREAM_CHECKSUM_EN.
module trivium_out_fifo #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_req,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [1:0]    fifo_cnd,
  output logic [AW:0]   fill_lvl,
  output logic          ovf_err
`ifdef STREAM_CHECKSUM_EN
  ,
  output logic [7:0]    blk_sum,
  output logic          blk_sum_vld
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FILL  = 2'b01,
    FULL  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fill_nxt;
  logic          wr_acc, rd_acc;

  always_comb begin
    wr_acc   = wr_en && (state == EMPTY || state == FILL) && (fill_lvl < FULL_LVL);
    rd_acc   = rd_req && (fill_lvl != '0) && (state != EMPTY);
    // transitions below are decided on the post-update count
    fill_nxt = fill_lvl + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= EMPTY;
    else if (clr) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (wr_acc) state_nxt = FILL;
      FILL: begin
        if (fill_nxt == FULL_LVL) state_nxt = FULL;
        else if (fill_nxt == '0)  state_nxt = EMPTY;
      end
      FULL:  if (rd_acc) state_nxt = DRAIN;
      DRAIN: if (fill_nxt == '0) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    fifo_cnd = state;
  end

  // Storage is not reset; contents are don't-care after reset/clear.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_lvl <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf_err  <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_lvl <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      fill_lvl <= fill_nxt;
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (wr_en && !wr_acc) ovf_err <= 1'b1;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef STREAM_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum        <= '0;
      blk_sum     <= '0;
      blk_sum_vld <= 1'b0;
    end else if (clr) begin
      csum        <= '0;
      blk_sum     <= '0;
      blk_sum_vld <= 1'b0;
    end else begin
      blk_sum_vld <= 1'b0;
      // the final byte is folded in on the same edge that completes the block
      if (state == FILL && state_nxt == FULL) begin
        blk_sum     <= csum ^ wr_data;
        blk_sum_vld <= 1'b1;
      end
      if (state_nxt == EMPTY) csum <= '0;
      else if (wr_acc)        csum <= csum ^ wr_data;
    end
  end
`endif

endmodule

// File: tb/tb_trivium_out_fifo.sv
// Scoreboard bench for trivium_out_fifo: expected read bytes queued at request time, checked by a monitor.
// Checksum checks are compiled in when STREAM_CHECKSUM_EN is defined.
module tb_trivium_out_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_req = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [1:0] fifo_cnd;
  logic [8:0] fill_lvl;
  logic       ovf_err;
`ifdef STREAM_CHECKSUM_EN
  logic [7:0] blk_sum;
  logic       blk_sum_vld;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  trivium_out_fifo #(.DEPTH(256), .AW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .fifo_cnd (fifo_cnd),
    .fill_lvl (fill_lvl),
    .ovf_err  (ovf_err)
`ifdef STREAM_CHECKSUM_EN
    ,
    .blk_sum     (blk_sum),
    .blk_sum_vld (blk_sum_vld)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rd_valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst && rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got rd_valid with data 0x%0h expected no read", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data != e) begin
          failures++;
          $display("FAIL rd_data: got 0x%0h expected 0x%0h", rd_data, e);
        end
      end
    end
  end

  task automatic read_n(input int n, input logic [7:0] first, input logic [7:0] step);
    logic [7:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      rd_req = 1'b1;
      exp_q.push_back(v);
      v = v + step;
      tick();
    end
    rd_req = 1'b0;
  endtask

  task automatic drain_wait(input string name);
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("rst_cnd", fifo_cnd, 0);
    chk("rst_fill", fill_lvl, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_rdata", rd_data, 0);

    // Full block 0x00..0xFF
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
      if (i == 0) chk("blk_cnd_first", fifo_cnd, 1);
      if (i == 254) chk("blk_fill_255", fill_lvl, 255);
    end
    wr_en = 1'b0;
    chk("blk_cnd_full", fifo_cnd, 2);
    chk("blk_fill_full", fill_lvl, 256);
    rd_req = 1'b1;
    exp_q.push_back(8'h00);
    tick();
    chk("blk_cnd_drain", fifo_cnd, 3);
    chk("blk_fill_drain", fill_lvl, 255);
    read_n(255, 8'h01, 8'h01);
    chk("blk_cnd_empty", fifo_cnd, 0);
    chk("blk_fill_empty", fill_lvl, 0);
    drain_wait("blk_pending");

    // Overflow: block of i*3, then a rejected 0xAA
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i * 3);
      tick();
    end
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("ovf_flag", ovf_err, 1);
    chk("ovf_fill", fill_lvl, 256);
    chk("ovf_cnd", fifo_cnd, 2);
    read_n(256, 8'h00, 8'h03);
    drain_wait("ovf_pending");
    chk("ovf_sticky", ovf_err, 1);
    chk("ovf_cnd_empty", fifo_cnd, 0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("empty_rd_valid", rd_valid, 0);
    chk("empty_rd_fill", fill_lvl, 0);
    chk("empty_rd_ovf", ovf_err, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovf", ovf_err, 0);
    chk("clr_rdata", rd_data, 0);

    // clr outranks simultaneous write and read
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h40 + i);
      tick();
    end
    clr = 1'b1;
    rd_req = 1'b1;
    tick();
    clr = 1'b0;
    wr_en = 1'b0;
    rd_req = 1'b0;
    chk("clr_prio_fill", fill_lvl, 0);
    chk("clr_prio_cnd", fifo_cnd, 0);
    chk("clr_prio_valid", rd_valid, 0);

    // Simultaneous read and write at fill_lvl=1
    wr_en = 1'b1;
    wr_data = 8'h5C;
    tick();
    chk("sim_fill_1", fill_lvl, 1);
    wr_data = 8'h3E;
    rd_req = 1'b1;
    exp_q.push_back(8'h5C);
    tick();
    wr_en = 1'b0;
    chk("sim_fill_keep", fill_lvl, 1);
    chk("sim_cnd_fill", fifo_cnd, 1);
    exp_q.push_back(8'h3E);
    tick();
    rd_req = 1'b0;
    chk("sim_cnd_empty", fifo_cnd, 0);
    chk("sim_fill_0", fill_lvl, 0);
    drain_wait("sim_pending");
    chk("sim_rdata_hold", rd_data, 8'h3E);

    // Asynchronous reset mid-block
    for (int i = 0; i < 100; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i + 7);
      tick();
    end
    wr_en = 1'b0;
    chk("mid_fill_100", fill_lvl, 100);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cnd", fifo_cnd, 0);
    chk("arst_fill", fill_lvl, 0);
    chk("arst_valid", rd_valid, 0);
    chk("arst_ovf", ovf_err, 0);
    chk("arst_rdata", rd_data, 0);
    #3;
    rst = 1'b1;
    tick();
    wr_en = 1'b1;
    wr_data = 8'h11;
    tick();
    wr_data = 8'h22;
    tick();
    wr_data = 8'h33;
    tick();
    wr_en = 1'b0;
    chk("post_rst_fill", fill_lvl, 3);
    read_n(3, 8'h11, 8'h11);
    drain_wait("post_rst_pending");
    chk("post_rst_cnd", fifo_cnd, 0);

`ifdef STREAM_CHECKSUM_EN
    // 256 x 0x01 XORs to 0x00
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h01;
      tick();
      if (i == 254) chk("sum_vld_early", blk_sum_vld, 0);
    end
    wr_en = 1'b0;
    chk("sum_vld_pulse", blk_sum_vld, 1);
    chk("sum_all_ones", blk_sum, 8'h00);
    tick();
    chk("sum_vld_drop", blk_sum_vld, 0);
    read_n(256, 8'h01, 8'h00);
    drain_wait("sum1_pending");
    // 0x01 followed by 255 x 0x00
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1;
      wr_data = (i == 0) ? 8'h01 : 8'h00;
      tick();
    end
    wr_en = 1'b0;
    chk("sum2_vld", blk_sum_vld, 1);
    chk("sum_single", blk_sum, 8'h01);
    rd_req = 1'b1;
    exp_q.push_back(8'h01);
    tick();
    read_n(255, 8'h00, 8'h00);
    drain_wait("sum2_pending");
`endif

    repeat (3) tick();
    chk("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trivium_out_fifo.md
Name: trivium_out_fifo

Overview:
- Output buffer sitting directly downstream of the Trivium cipher core.
- Captures each ciphertext byte presented with the write strobe and holds a full 256-byte secret block.
- Returns the 2-bit fill condition the cipher polls before starting the next block.
- Releases bytes to a byte-serial consumer (host/UART bridge) via a request/valid read port with 1-cycle latency.

Parameters:
- DEPTH, 256, buffer depth in bytes; must be a power of two, 2..256.
- AW, 8, address width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear (cipher total-reset status bit); same effect as reset, but on the clock edge
- wr_en  in  1  write strobe, one byte per cycle high (cipher wt_sgn)
- wr_data  in  8  ciphertext byte (cipher stream)
- rd_req  in  1  consumer requests one byte
- rd_data  out  8  read byte, valid when rd_valid=1
- rd_valid  out  1  one-cycle pulse, rd_data valid
- fifo_cnd  out  2  buffer condition to cipher
- fill_lvl  out  AW+1  current byte count, 0..DEPTH
- ovf_err  out  1  sticky: write arrived while not accepting

Behaviour:
- Reset (rst=0, asynchronous) and clr=1 (synchronous) both produce:
  - state=EMPTY; pointers=0; fill_lvl=0; fifo_cnd=00
  - rd_data=0; rd_valid=0; ovf_err=0
  - Buffer contents are don't-care.
  - clr has priority over wr_en and rd_req in the same cycle.
- Storage: DEPTH x 8 array; wr_ptr/rd_ptr are AW bits and wrap naturally at DEPTH. fill_lvl is a separate AW+1-bit counter.
- State machine (registered; fifo_cnd = state code):
  - EMPTY (00): wr_en -> FILL. rd_req is ignored.
  - FILL (01):
    - writes and reads both accepted
    - fill_lvl reaches DEPTH -> FULL
    - fill_lvl reaches 0 -> EMPTY
  - FULL (10): writes rejected. First accepted rd_req -> DRAIN.
  - DRAIN (11): writes rejected. Reads continue; fill_lvl reaches 0 -> EMPTY.
- Cipher behaviour: the cipher stalls in its ready state until fifo_cnd==00. A full block is therefore always drained completely before the next block starts.
- Write acceptance:
  - Condition: wr_en=1 and state in {EMPTY, FILL} and fill_lvl<DEPTH.
  - Effect: mem[wr_ptr]<=wr_data; wr_ptr+1.
  - Rejected write: data dropped, ovf_err<=1. ovf_err is cleared only by rst or clr.
- Read acceptance:
  - Condition: rd_req=1 and fill_lvl>0 and state != EMPTY.
  - Next cycle: rd_data<=mem[rd_ptr]; rd_valid=1; rd_ptr+1.
  - rd_req with fill_lvl=0: no effect, no error, rd_valid=0.
  - rd_data holds its last value when rd_valid=0.
- Simultaneous accepted read and write in FILL:
  - fill_lvl unchanged; state stays FILL.
  - When fill_lvl=1, the read returns the old byte, never the byte written that cycle.
- Transitions use the post-update fill_lvl. Example: in FILL at DEPTH-1, a write without a read goes to FULL in the same edge.
- fill_lvl never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: STREAM_CHECKSUM_EN.
- With the macro defined:
  - Ports added: blk_sum out 8, blk_sum_vld out 1.
  - Running XOR of every accepted byte, cleared on entry to EMPTY and by rst/clr.
  - On the transition FILL->FULL, blk_sum is loaded with the XOR including the final byte, and blk_sum_vld pulses for 1 cycle.
  - Reset values: blk_sum=0, blk_sum_vld=0.
- Without the macro: these ports and the logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: release rst, hold all inputs low for 10 cycles -> fifo_cnd=00, fill_lvl=0, rd_valid=0, ovf_err=0.
- Full block: write bytes 0x00..0xFF on 256 consecutive cycles -> fifo_cnd 01 after first write, 10 after the 256th, fill_lvl=256. Then pulse rd_req 256 times -> rd_data sequence 0x00..0xFF, each 1 cycle after its request; fifo_cnd 11 from the first read, 00 after the last, fill_lvl=0.
- Overflow: fill 256 bytes, then write 0xAA -> ovf_err=1, fill_lvl stays 256. Drain all -> no 0xAA is returned; ovf_err stays 1 until clr pulse.
- Simultaneous: in FILL with fill_lvl=1 holding 0x5C, assert wr_en (0x3E) and rd_req together -> rd_data=0x5C next cycle, fill_lvl=1, state FILL; a second read returns 0x3E and state becomes EMPTY.
- Reset mid-operation: after 100 writes, assert rst low asynchronously between edges -> outputs return to reset values immediately. After release, 3 writes then 3 reads return exactly those 3 bytes.
- Checksum (STREAM_CHECKSUM_EN): write 256 bytes all 0x01 -> blk_sum=0x00 with a 1-cycle blk_sum_vld pulse. Write 0x01 followed by 255 bytes of 0x00 -> blk_sum=0x01.
